rans_dec: RTL and testbench
===========================

# rans_dec

Single-stream rANS decoder, the receive-side counterpart of the `rans` encoder lanes. It holds a symbol frequency table loaded over the same write port the encoder uses. It consumes the byte-reversed encoder output one byte at a time and emits decoded symbols over a valid/ready handshake. It also checks the final coder state against the encoder's initial state.

## Interface
- `RESOLUTION`, 10: probability precision R; total frequency M = 2^R.
- `SYMBOL_WIDTH`, 8: symbol width; the alphabet has 2^SYMBOL_WIDTH entries.
- `clk_i` in 1: clock. One clock; all logic on rising edge.
- `rst_i` in 1: reset; synchronous, active-high.
- `freq_wr_i` in 1: table write strobe.
- `freq_i` in RESOLUTION: frequency of `symb_i`.
- `cum_freq_i` in RESOLUTION: cumulative frequency of `symb_i`.
- `symb_i` in SYMBOL_WIDTH: symbol addressed by the table write.
- `tbl_busy_o` out 1: slot-table fill in progress.
- `start_i` in 1: begin a frame.
- `num_symb_i` in 16: symbol count for the frame; latched on the `start_i` cycle.
- `byte_valid_i` in 1, `byte_i` in 8, `byte_ready_o` out 1: compressed byte input. A transfer occurs when valid and ready are both high.
- `valid_o` out 1, `symb_o` out SYMBOL_WIDTH, `ready_i` in 1: decoded symbol output.
- `done_o` out 1: frame complete.
- `state_ok_o` out 1: final state equals RANS_L; valid while `done_o` is high.

## Operation
- Coder state x is 32 bits. RANS_L = 2^23. Renormalisation is byte-wise.
- Table write (accepted only when `tbl_busy_o`=0 and the FSM is in IDLE or DONE; otherwise ignored):
  - Store freq and cum at index `symb_i`.
  - Then write `symb_i` into slot2sym[cum .. cum+freq-1], one slot per cycle, with `tbl_busy_o` high.
  - freq=0 performs no fill and `tbl_busy_o` stays low.
  - Slot addresses wrap modulo M.
- `start_i` is accepted only in IDLE or DONE with `tbl_busy_o`=0; otherwise ignored. Acceptance latches `num_symb_i`, clears `done_o` and `state_ok_o`, and enters INIT.
- FSM states:
  - IDLE
  - INIT: take 4 bytes; x = {b0,b1,b2,b3}, first byte is the MSB. Go to DONE if count=0, else LOOKUP.
  - LOOKUP: read slot2sym at slot = x[R-1:0].
  - FETCH: read freq[s] and cum[s].
  - UPDATE: x = freq·(x>>R) + slot − cum. Go to EMIT.
  - EMIT: `valid_o`=1 with `symb_o`=s; held stable until `ready_i`.
  - RENORM: while x < RANS_L, take a byte, x = (x<<8) | byte. Count decrements on the EMIT handshake. When x ≥ RANS_L, go to DONE if count=0, else LOOKUP.
  - DONE: `done_o`=1, `state_ok_o` = (x == RANS_L).
- Arithmetic: the product is freq (R bits) × (32−R bits) and fits in 32 bits. slot − cum is non-negative for a consistent table. Inconsistent tables produce undefined symbols but no lockup.
- `byte_ready_o` is high only in INIT and in RENORM while x < RANS_L.

## Timing
- Reset: all outputs are 0 and the FSM is in IDLE. Table RAM contents are retained.
- Reset mid-frame or mid-fill aborts to IDLE at the next edge.
- Table write: freq/cum are written the cycle after the strobe. `tbl_busy_o` rises on that cycle and stays high for exactly freq cycles.
- Per-symbol latency with no stalls and no renorm: LOOKUP, FETCH, UPDATE, then `valid_o` in the 4th cycle after the LOOKUP entry.
- Each consumed renorm byte costs 1 cycle. Input stalls (`byte_valid_i`=0) hold the state.
- A `start_i` in the same cycle as a `freq_wr_i` in IDLE or DONE: the write wins and `start_i` is ignored.
- `done_o` stays high until the next accepted `start_i` or reset.

## Structure
- Package `rans_pkg`: STATE_WIDTH=32, RANS_L, IO_BITS=8, the decoder FSM state enum. The encoder lanes use the same constants.
- Sub-module `rans_dec_tables`:
  - freq/cum RAM of 2^SYMBOL_WIDTH entries.
  - slot2sym RAM of 2^RESOLUTION entries.
  - Fill counter/FSM and `tbl_busy_o`.
  - All reads are synchronous, 1-cycle.

## Test plan
- Table R=10: 0x41 freq 512 cum 0; 0x42 freq 512 cum 512. Start with num_symb=1, bytes 01 00 00 00 → `symb_o`=0x41, 0 renorm bytes, `done_o`=1, `state_ok_o`=1.
- Same table, bytes 01 00 02 00 → `symb_o`=0x42, `state_ok_o`=1.
- Table: 0x41 freq 1023 cum 0; 0x43 freq 1 cum 1023. Bytes 00 80 03 FF AB CD → `symb_o`=0x43, exactly 2 renorm bytes consumed, x=0x2000ABCD, `state_ok_o`=0.
- Hold `ready_i`=0 for 5 cycles in EMIT → `valid_o` and `symb_o` are stable, `byte_ready_o`=0, no byte consumed.
- Write freq 4 cum 1022 → `tbl_busy_o` high for 4 cycles; slots 1022, 1023, 0, 1 hold the symbol. `start_i` during busy is ignored.
- Assert `rst_i` in RENORM → the next cycle has all outputs 0, state IDLE. A subsequent frame from the first test still decodes 0x41 without reloading the table.

Source files
------------

// File: rtl/rans_pkg.sv
// Shared rANS constants and the decoder FSM encoding.
// The encoder lanes use the same state width and renormalisation bound.
package rans_pkg;

  localparam int STATE_WIDTH = 32;
  localparam int IO_BITS     = 8;
  localparam logic [STATE_WIDTH-1:0] RANS_L = 32'h0080_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_LOOKUP,
    ST_FETCH,
    ST_UPDATE,
    ST_EMIT,
    ST_RENORM,
    ST_DONE
  } dec_state_e;

endpackage

// File: rtl/rans_dec_tables.sv
// Decoder tables: per-symbol freq/cum RAM and slot-to-symbol RAM, plus the
// slot fill engine that expands one table write into freq slot entries.
module rans_dec_tables #(
  parameter int RESOLUTION   = 10,
  parameter int SYMBOL_WIDTH = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    wr_i,
  input  logic [RESOLUTION-1:0]   freq_i,
  input  logic [RESOLUTION-1:0]   cum_i,
  input  logic [SYMBOL_WIDTH-1:0] symb_i,
  output logic                    busy_o,
  input  logic [RESOLUTION-1:0]   slot_addr_i,
  output logic [SYMBOL_WIDTH-1:0] slot_sym_o,
  input  logic [SYMBOL_WIDTH-1:0] sym_addr_i,
  output logic [RESOLUTION-1:0]   freq_o,
  output logic [RESOLUTION-1:0]   cum_o
);

  localparam int NUM_SYM  = 1 << SYMBOL_WIDTH;
  localparam int NUM_SLOT = 1 << RESOLUTION;

  logic [2*RESOLUTION-1:0] fc_mem   [NUM_SYM];
  logic [SYMBOL_WIDTH-1:0] slot_mem [NUM_SLOT];

  logic [2*RESOLUTION-1:0] fc_rd_q;
  logic [SYMBOL_WIDTH-1:0] slot_rd_q;

  logic                    pend_q, pend_d;
  logic                    busy_q, busy_d;
  logic [RESOLUTION-1:0]   fill_addr_q, fill_addr_d;
  logic [RESOLUTION-1:0]   fill_left_q, fill_left_d;
  logic [SYMBOL_WIDTH-1:0] fill_sym_q, fill_sym_d;

  // On the cycle after the strobe, fill_left/fill_addr still hold the original
  // freq/cum, so they double as the freq/cum RAM write data.
  always_comb begin
    pend_d      = 1'b0;
    busy_d      = busy_q;
    fill_addr_d = fill_addr_q;
    fill_left_d = fill_left_q;
    fill_sym_d  = fill_sym_q;
    if (wr_i && !busy_q) begin
      pend_d      = 1'b1;
      busy_d      = (freq_i != '0);
      fill_addr_d = cum_i;
      fill_left_d = freq_i;
      fill_sym_d  = symb_i;
    end else if (busy_q) begin
      fill_addr_d = fill_addr_q + RESOLUTION'(1);
      fill_left_d = fill_left_q - RESOLUTION'(1);
      busy_d      = (fill_left_q != RESOLUTION'(1));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q      <= 1'b0;
      busy_q      <= 1'b0;
      fill_addr_q <= '0;
      fill_left_q <= '0;
      fill_sym_q  <= '0;
    end else begin
      pend_q      <= pend_d;
      busy_q      <= busy_d;
      fill_addr_q <= fill_addr_d;
      fill_left_q <= fill_left_d;
      fill_sym_q  <= fill_sym_d;
    end
  end

  // RAM contents are deliberately untouched by reset.
  always_ff @(posedge clk_i) begin
    if (pend_q && !rst_i) fc_mem[fill_sym_q] <= {fill_left_q, fill_addr_q};
    if (busy_q && !rst_i) slot_mem[fill_addr_q] <= fill_sym_q;
    slot_rd_q <= slot_mem[slot_addr_i];
    fc_rd_q   <= fc_mem[sym_addr_i];
  end

  assign busy_o     = busy_q;
  assign slot_sym_o = slot_rd_q;
  assign freq_o     = fc_rd_q[2*RESOLUTION-1:RESOLUTION];
  assign cum_o      = fc_rd_q[RESOLUTION-1:0];

endmodule

// File: rtl/rans_dec.sv
// Single-stream rANS decoder: byte-wise input, symbol output with valid/ready,
// final-state check against RANS_L.
module rans_dec
  import rans_pkg::*;
#(
  parameter int RESOLUTION   = 10,
  parameter int SYMBOL_WIDTH = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    freq_wr_i,
  input  logic [RESOLUTION-1:0]   freq_i,
  input  logic [RESOLUTION-1:0]   cum_freq_i,
  input  logic [SYMBOL_WIDTH-1:0] symb_i,
  output logic                    tbl_busy_o,
  input  logic                    start_i,
  input  logic [15:0]             num_symb_i,
  input  logic                    byte_valid_i,
  input  logic [IO_BITS-1:0]      byte_i,
  output logic                    byte_ready_o,
  output logic                    valid_o,
  output logic [SYMBOL_WIDTH-1:0] symb_o,
  input  logic                    ready_i,
  output logic                    done_o,
  output logic                    state_ok_o
);

  dec_state_e              state_q, state_d;
  logic [STATE_WIDTH-1:0]  x_q, x_d;
  logic [15:0]             cnt_q, cnt_d;
  logic [1:0]              init_idx_q, init_idx_d;
  logic [SYMBOL_WIDTH-1:0] sym_q, sym_d;

  logic                    tbl_busy;
  logic [SYMBOL_WIDTH-1:0] slot_sym;
  logic [RESOLUTION-1:0]   freq_rd, cum_rd;
  logic                    idle_or_done, tbl_wr, start_ok, below_l;
  logic [STATE_WIDTH-1:0]  x_upd;

  assign idle_or_done = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign tbl_wr       = freq_wr_i && idle_or_done && !tbl_busy;
  // A simultaneous table write takes priority over a frame start.
  assign start_ok     = start_i && !freq_wr_i && idle_or_done && !tbl_busy;
  assign below_l      = (x_q < RANS_L);
  // Slot is still x[R-1:0] here because x only changes at the end of UPDATE.
  assign x_upd = STATE_WIDTH'(freq_rd) * (x_q >> RESOLUTION)
               + STATE_WIDTH'(x_q[RESOLUTION-1:0]) - STATE_WIDTH'(cum_rd);

  rans_dec_tables #(
    .RESOLUTION  (RESOLUTION),
    .SYMBOL_WIDTH(SYMBOL_WIDTH)
  ) u_tables (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wr_i       (tbl_wr),
    .freq_i     (freq_i),
    .cum_i      (cum_freq_i),
    .symb_i     (symb_i),
    .busy_o     (tbl_busy),
    .slot_addr_i(x_q[RESOLUTION-1:0]),
    .slot_sym_o (slot_sym),
    .sym_addr_i (slot_sym),
    .freq_o     (freq_rd),
    .cum_o      (cum_rd)
  );

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    cnt_d        = cnt_q;
    init_idx_d   = init_idx_q;
    sym_d        = sym_q;
    byte_ready_o = 1'b0;
    valid_o      = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_ok) begin
          state_d    = ST_INIT;
          cnt_d      = num_symb_i;
          init_idx_d = '0;
        end
      end
      ST_INIT: begin
        byte_ready_o = 1'b1;
        if (byte_valid_i) begin
          x_d        = {x_q[STATE_WIDTH-IO_BITS-1:0], byte_i};
          init_idx_d = init_idx_q + 2'd1;
          if (init_idx_q == 2'd3) state_d = (cnt_q == '0) ? ST_DONE : ST_LOOKUP;
        end
      end
      ST_LOOKUP: state_d = ST_FETCH;
      ST_FETCH: begin
        sym_d   = slot_sym;
        state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        x_d     = x_upd;
        state_d = ST_EMIT;
      end
      ST_EMIT: begin
        valid_o = 1'b1;
        if (ready_i) begin
          cnt_d   = cnt_q - 16'd1;
          state_d = ST_RENORM;
        end
      end
      ST_RENORM: begin
        if (below_l) begin
          byte_ready_o = 1'b1;
          if (byte_valid_i) x_d = {x_q[STATE_WIDTH-IO_BITS-1:0], byte_i};
        end else begin
          state_d = (cnt_q == '0) ? ST_DONE : ST_LOOKUP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      x_q        <= '0;
      cnt_q      <= '0;
      init_idx_q <= '0;
      sym_q      <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      cnt_q      <= cnt_d;
      init_idx_q <= init_idx_d;
      sym_q      <= sym_d;
    end
  end

  assign tbl_busy_o = tbl_busy;
  assign symb_o     = sym_q;
  assign done_o     = (state_q == ST_DONE);
  assign state_ok_o = done_o && (x_q == RANS_L);

endmodule

// File: tb/tb_rans_dec.sv
// Directed bench for rans_dec: table fills, frame decodes, renorm, stalls,
// reset recovery and slot wrap, with hand-computed expected values.
module tb_rans_dec;

  localparam int R  = 10;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          freq_wr_i = 1'b0;
  logic [R-1:0]  freq_i = '0;
  logic [R-1:0]  cum_freq_i = '0;
  logic [SW-1:0] symb_i = '0;
  logic          tbl_busy_o;
  logic          start_i = 1'b0;
  logic [15:0]   num_symb_i = '0;
  logic          byte_valid_i = 1'b0;
  logic [7:0]    byte_i = '0;
  logic          byte_ready_o;
  logic          valid_o;
  logic [SW-1:0] symb_o;
  logic          ready_i = 1'b1;
  logic          done_o;
  logic          state_ok_o;

  always #5 clk = ~clk;

  rans_dec #(.RESOLUTION(R), .SYMBOL_WIDTH(SW)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .freq_wr_i   (freq_wr_i),
    .freq_i      (freq_i),
    .cum_freq_i  (cum_freq_i),
    .symb_i      (symb_i),
    .tbl_busy_o  (tbl_busy_o),
    .start_i     (start_i),
    .num_symb_i  (num_symb_i),
    .byte_valid_i(byte_valid_i),
    .byte_i      (byte_i),
    .byte_ready_o(byte_ready_o),
    .valid_o     (valid_o),
    .symb_o      (symb_o),
    .ready_i     (ready_i),
    .done_o      (done_o),
    .state_ok_o  (state_ok_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] fb [16];
  int         fb_n;
  logic [7:0] got_syms [8];
  int         got_nsym, bytes_used, lat, busy_cycles;
  int         stall_bad, stall_bytes, stall_seen;
  logic       got_done, got_ok;

  task automatic set_frame(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) fb[i] = v[8*(n-1-i) +: 8];
    fb_n = n;
  endtask

  task automatic write_entry(input logic [7:0] s, input logic [R-1:0] f,
                             input logic [R-1:0] c, input logic hold_start);
    freq_wr_i = 1'b1; symb_i = s; freq_i = f; cum_freq_i = c;
    start_i = hold_start; num_symb_i = 16'd1;
    @(posedge clk); #1;
    freq_wr_i = 1'b0;
    busy_cycles = 0;
    while (tbl_busy_o && busy_cycles < 2000) begin
      busy_cycles++;
      @(posedge clk); #1;
    end
    start_i = 1'b0;
  endtask

  // Drives one frame from fb[] and records what the DUT produced.
  task automatic run_frame(input logic [15:0] n, input int stall, input int max_cyc);
    int bi, cyc, lat_cnt, stall_left;
    logic counting, stall_started;
    logic [7:0] stall_sym;
    bi = 0; cyc = 0; lat_cnt = 0; counting = 1'b0; stall_started = 1'b0;
    stall_left = 0; stall_sym = '0;
    got_nsym = 0; lat = -1; stall_bad = 0; stall_bytes = 0; stall_seen = 0;
    num_symb_i = n; start_i = 1'b1; ready_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    while (!done_o && cyc < max_cyc) begin
      byte_valid_i = (bi < fb_n);
      byte_i = (bi < fb_n) ? fb[bi] : 8'h00;
      if (counting) lat_cnt++;
      if (valid_o && !stall_started && stall > 0) begin
        stall_started = 1'b1; stall_left = stall; stall_sym = symb_o;
      end
      if (stall_left > 0) begin
        ready_i = 1'b0; stall_seen++; stall_left--;
        if (!valid_o || symb_o !== stall_sym || byte_ready_o) stall_bad++;
        if (byte_ready_o && byte_valid_i) begin stall_bytes++; bi++; end
      end else begin
        ready_i = 1'b1;
        if (valid_o) begin
          if (got_nsym < 8) got_syms[got_nsym] = symb_o;
          got_nsym++;
          if (counting) begin lat = lat_cnt; counting = 1'b0; end
        end
        if (byte_ready_o && byte_valid_i) begin
          bi++;
          if (bi == 4) begin counting = 1'b1; lat_cnt = 0; end
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    byte_valid_i = 1'b0; ready_i = 1'b1;
    got_done = done_o; got_ok = state_ok_o; bytes_used = bi;
    $display("[TB] frame n=%0d: nsym=%0d last=%02h bytes=%0d done=%0b ok=%0b lat=%0d",
             n, got_nsym, got_syms[0], bytes_used, got_done, got_ok, lat);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({valid_o, byte_ready_o, done_o, state_ok_o, tbl_busy_o, symb_o} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected all zero",
               {valid_o, byte_ready_o, done_o, state_ok_o, tbl_busy_o, symb_o});
    end
    rst_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    write_entry(8'h41, 10'd512, 10'd0, 1'b0);
    n_tests++;
    if (busy_cycles !== 512) begin
      n_fail++; $display("FAIL fill_512_busy: got %0d expected 512", busy_cycles);
    end
    write_entry(8'h42, 10'd512, 10'd512, 1'b0);
    set_frame(64'h01000000, 4);
    run_frame(16'd1, 0, 200);
    n_tests++;
    if (got_nsym !== 1 || got_syms[0] !== 8'h41) begin
      n_fail++; $display("FAIL basic_sym: got n=%0d sym=%02h expected n=1 sym=41", got_nsym, got_syms[0]);
    end
    n_tests++;
    if (bytes_used !== 4 || got_done !== 1'b1 || got_ok !== 1'b1) begin
      n_fail++; $display("FAIL basic_end: got bytes=%0d done=%0b ok=%0b expected 4 1 1", bytes_used, got_done, got_ok);
    end
    n_tests++;
    if (lat !== 4) begin
      n_fail++; $display("FAIL basic_latency: got %0d expected 4", lat);
    end
    set_frame(64'h01000200, 4);
    run_frame(16'd1, 0, 200);
    n_tests++;
    if (got_syms[0] !== 8'h42 || got_done !== 1'b1 || got_ok !== 1'b1) begin
      n_fail++; $display("FAIL second_sym: got sym=%02h done=%0b ok=%0b expected 42 1 1", got_syms[0], got_done, got_ok);
    end
  endtask

  task automatic test_back_to_back();
    set_frame(64'h0100020077, 5);
    run_frame(16'd2, 0, 200);
    n_tests++;
    if (got_nsym !== 2 || got_syms[0] !== 8'h42 || got_syms[1] !== 8'h41) begin
      n_fail++; $display("FAIL b2b_syms: got n=%0d %02h %02h expected 2 42 41", got_nsym, got_syms[0], got_syms[1]);
    end
    n_tests++;
    if (bytes_used !== 5 || got_done !== 1'b1 || got_ok !== 1'b0) begin
      n_fail++; $display("FAIL b2b_end: got bytes=%0d done=%0b ok=%0b expected 5 1 0", bytes_used, got_done, got_ok);
    end
  endtask

  task automatic test_renorm();
    write_entry(8'h41, 10'd1023, 10'd0, 1'b0);
    n_tests++;
    if (busy_cycles !== 1023) begin
      n_fail++; $display("FAIL fill_1023_busy: got %0d expected 1023", busy_cycles);
    end
    write_entry(8'h43, 10'd1, 10'd1023, 1'b0);
    set_frame(64'h008003FFABCDEE, 7);
    run_frame(16'd1, 0, 200);
    n_tests++;
    if (got_syms[0] !== 8'h43 || bytes_used !== 6) begin
      n_fail++; $display("FAIL renorm_sym_bytes: got sym=%02h bytes=%0d expected 43 6", got_syms[0], bytes_used);
    end
    n_tests++;
    if (got_done !== 1'b1 || got_ok !== 1'b0) begin
      n_fail++; $display("FAIL renorm_end: got done=%0b ok=%0b expected 1 0", got_done, got_ok);
    end
  endtask

  task automatic test_stall();
    set_frame(64'h008003FFABCDEE, 7);
    run_frame(16'd1, 5, 200);
    n_tests++;
    if (stall_seen !== 5 || stall_bad !== 0 || stall_bytes !== 0) begin
      n_fail++; $display("FAIL stall_hold: got seen=%0d bad=%0d bytes=%0d expected 5 0 0", stall_seen, stall_bad, stall_bytes);
    end
    n_tests++;
    if (got_nsym !== 1 || got_syms[0] !== 8'h43 || bytes_used !== 6 || got_done !== 1'b1) begin
      n_fail++; $display("FAIL stall_result: got n=%0d sym=%02h bytes=%0d done=%0b expected 1 43 6 1",
                         got_nsym, got_syms[0], bytes_used, got_done);
    end
  endtask

  task automatic test_reset_renorm();
    set_frame(64'h008003FF, 4);
    run_frame(16'd1, 0, 20);
    n_tests++;
    if (byte_ready_o !== 1'b1 || done_o !== 1'b0) begin
      n_fail++; $display("FAIL renorm_wait: got byte_ready=%0b done=%0b expected 1 0", byte_ready_o, done_o);
    end
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    n_tests++;
    if ({valid_o, byte_ready_o, done_o, state_ok_o, tbl_busy_o, symb_o} !== 13'h0) begin
      n_fail++; $display("FAIL reset_mid_frame: got %b expected all zero",
                         {valid_o, byte_ready_o, done_o, state_ok_o, tbl_busy_o, symb_o});
    end
    set_frame(64'h01000000, 4);
    run_frame(16'd1, 0, 200);
    n_tests++;
    if (got_syms[0] !== 8'h41 || got_done !== 1'b1 || bytes_used !== 4) begin
      n_fail++; $display("FAIL after_reset_decode: got sym=%02h done=%0b bytes=%0d expected 41 1 4",
                         got_syms[0], got_done, bytes_used);
    end
  endtask

  task automatic test_fill_wrap();
    logic [63:0] fv [4];
    int          fn [4];
    logic [7:0]  es [4];
    int          eb [4];
    logic        eo [4];
    fv = '{64'h008003FE00, 64'h0100000000, 64'h0080000100_00, 64'h0080000200};
    fn = '{5, 5, 6, 5};
    es = '{8'h44, 8'h44, 8'h44, 8'h41};
    eb = '{5, 5, 6, 5};
    eo = '{1'b1, 1'b0, 1'b0, 1'b0};
    // start held through the strobe and busy cycles must be ignored
    write_entry(8'h44, 10'd4, 10'd1022, 1'b1);
    n_tests++;
    if (busy_cycles !== 4) begin
      n_fail++; $display("FAIL wrap_busy: got %0d expected 4", busy_cycles);
    end
    n_tests++;
    if (done_o !== 1'b1 || byte_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL start_ignored: got done=%0b byte_ready=%0b expected 1 0", done_o, byte_ready_o);
    end
    for (int k = 0; k < 4; k++) begin
      set_frame(fv[k], fn[k]);
      run_frame(16'd1, 0, 200);
      n_tests++;
      if (got_syms[0] !== es[k] || bytes_used !== eb[k] || got_done !== 1'b1 || got_ok !== eo[k]) begin
        n_fail++; $display("FAIL wrap_frame%0d: got sym=%02h bytes=%0d done=%0b ok=%0b expected %02h %0d 1 %0b",
                           k, got_syms[0], bytes_used, got_done, got_ok, es[k], eb[k], eo[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_renorm();
    test_stall();
    test_reset_renorm();
    test_fill_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
